// File: rtl/bus_master_if.sv
// bus_master_if: single-outstanding CPU-to-bus master. Latches one CPU load or
// store, requests the bus, performs one transfer and releases the CPU stall.
// Optional feature: define BUSIF_TIMEOUT_EN to abort a request that is not
// granted within 255 REQ cycles (sticky err, all-ones load result).
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Read
`define Read 1'b1
`endif
`ifndef Write
`define Write 1'b0
`endif

module bus_master_if #(
  parameter int ADDR_W = `BUS_ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              breq_,
  input  logic              bgrt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_rw_,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    XFER   = 3'd2,
    RDWAIT = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              req_s;
  logic              grant_s;
  logic              timeout_s;

  assign req_s   = cpu_memread | cpu_memwrite;
  assign grant_s = (bgrt_ == `Enable_);

`ifdef BUSIF_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Timeout fires on the 255th consecutive REQ cycle without a grant.
  assign timeout_s = (state_q == REQ) && !grant_s && (cnt_q == 8'd254);

  // Count grantless REQ cycles; any exit from REQ clears the count.
  always_comb begin
    cnt_d = 8'd0;
    if ((state_q == REQ) && !grant_s && !timeout_s) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    err_d = err_q | timeout_s;
  end

  // Timeout counter and sticky error flag (cleared only by reset).
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one latched operation walks REQ -> XFER -> (RDWAIT) -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_s ? REQ : IDLE;
      REQ: begin
        if (grant_s) begin
          state_d = XFER;
        end else if (timeout_s) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      XFER:    state_d = (rw_q == `Read) ? RDWAIT : DONE;
      RDWAIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: stall/request follow the state; the bus is only driven as a write in XFER.
  always_comb begin
    cpu_stall = 1'b0;
    breq_     = 1'b1;
    bus_rw_   = `Read;
    case (state_q)
      IDLE:   cpu_stall = req_s;
      REQ: begin
        cpu_stall = 1'b1;
        breq_     = 1'b0;
      end
      XFER: begin
        cpu_stall = 1'b1;
        breq_     = 1'b0;
        bus_rw_   = rw_q;
      end
      RDWAIT: begin
        cpu_stall = 1'b1;
        breq_     = 1'b0;
      end
      DONE:    cpu_stall = 1'b0;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Datapath next values: latch the request in IDLE, capture load data in RDWAIT.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    if ((state_q == IDLE) && req_s) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      rw_d    = cpu_memread ? `Read : `Write;  // read wins when both are asserted
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
    end
    if (state_q == RDWAIT) begin
      rdata_d = bus_rdata;
    end else if (timeout_s && (rw_q == `Read)) begin
      rdata_d = {DATA_W{1'b1}};
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rw_q    <= `Read;
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed and randomized CPU operations
// compared against a transaction-level model (latency, request window length,
// bus write events, load result, error flag).
module tb_bus_master_if;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef BUSIF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_;
  logic          cpu_memread, cpu_memwrite;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall, breq_, bgrt_;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          bus_rw_, err;

  int tests = 0;
  int fails = 0;

  // Model state carried between transactions.
  logic [DW-1:0] m_rdata;
  logic          m_err;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_(reset_),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .breq_(breq_), .bgrt_(bgrt_),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rw_(bus_rw_),
    .bus_rdata(bus_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU operation; the bench acts as arbiter (grant after 'delay' REQ cycles)
  // and device (read data valid the cycle after the address is driven).
  task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] dev, input int delay);
    int n = 0, reqc = 0, g = 0, lat = 0, blow = 0, wcnt = 0;
    int exp_lat, exp_blow, exp_wcnt;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wdat = '0, rd_obs = '0;
    logic breq_done = 1'b0;
    logic is_read, to;
    bit done = 1'b0;

    is_read = rd;
    to      = TO_EN && (delay >= 255);

    @(posedge clk); #1;
    cpu_memread = rd; cpu_memwrite = wr; cpu_addr = a; cpu_wdata = wd;
    bgrt_ = 1'b1; bus_rdata = ~dev;
    n = 1;
    while (!done && n <= 400) begin
      @(negedge clk);
      if (n == 1) begin
        check("idle_stall", cpu_stall, 1);
        check("idle_breq", breq_, 1);
      end
      if (breq_ === 1'b0) blow++;
      if (bus_rw_ === 1'b0) begin
        wcnt++;
        wa = bus_addr;
        wdat = bus_wdata;
      end
      if (g != 0 && n == g + 1) check("xfer_addr", bus_addr, a);
      if (cpu_stall === 1'b0) begin
        done = 1'b1;
        lat = n;
        breq_done = breq_;
        rd_obs = cpu_rdata;
      end else begin
        @(posedge clk); #1;
        n++;
        if (breq_ === 1'b0) begin
          reqc++;
          if (g == 0) begin
            if (reqc > delay) begin
              bgrt_ = 1'b0;
              g = n;
            end else begin
              bgrt_ = 1'b1;
            end
          end else begin
            bgrt_ = 1'($urandom_range(0, 1));
          end
        end else begin
          bgrt_ = 1'b1;
        end
        bus_rdata = (g != 0 && n == g + 2) ? dev : ~dev;
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
      end
    end

    // Reference: IDLE + REQ waits + XFER (+ RDWAIT for loads), stall drops next cycle.
    if (to) begin
      exp_blow = 255;
      exp_wcnt = 0;
    end else begin
      exp_blow = (delay + 1) + 1 + (is_read ? 1 : 0);
      exp_wcnt = is_read ? 0 : 1;
    end
    exp_lat = 1 + exp_blow + 1;
    if (is_read) m_rdata = to ? {DW{1'b1}} : dev;
    if (to) m_err = 1'b1;

    check("latency", lat, exp_lat);
    check("breq_low_cycles", blow, exp_blow);
    check("breq_high_in_done", breq_done, 1);
    check("write_count", wcnt, exp_wcnt);
    if (exp_wcnt == 1) begin
      check("write_addr", wa, a);
      check("write_data", wdat, wd);
    end
    check("cpu_rdata", rd_obs, m_rdata);
    check("err", err, m_err);
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0; bgrt_ = 1'b1;
    repeat (k) @(negedge clk);
    check("idle_no_stall", cpu_stall, 0);
    check("idle_rw_read", bus_rw_, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, w;
    bit seen;
    int wc;

    reset_ = 1'b0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; bgrt_ = 1'b1; bus_rdata = '0;
    m_rdata = '0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_breq", breq_, 1);
    check("rst_stall", cpu_stall, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rw", bus_rw_, 1);
    check("rst_err", err, 0);
    reset_ = 1'b1;

    // Directed: load with immediate grant, store with delayed grant.
    run_txn(1'b1, 1'b0, 16'h0010, 16'h1234, 16'h00A5, 0);
    idle(2);
    run_txn(1'b0, 1'b1, 16'h0020, 16'h003C, 16'h5A5A, 3);
    idle(1);
    // Both strobes high: must be a load.
    run_txn(1'b1, 1'b1, 16'h0030, 16'hDEAD, 16'h7E81, 1);
    // Back-to-back loads, request held straight into the next IDLE cycle.
    run_txn(1'b1, 1'b0, 16'h0001, 16'h0000, DW'($urandom), 0);
    run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, DW'($urandom), 0);
    idle(1);

    // Randomized operations.
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(r, w, AW'($urandom), DW'($urandom), DW'($urandom), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    // Grant withheld for a long time: timeout when enabled, otherwise an indefinite wait.
    run_txn(1'b1, 1'b0, 16'h0044, 16'h0000, 16'h1357, 300);
    idle(1);
    run_txn(1'b1, 1'b0, 16'h0045, 16'h0000, 16'h2468, 0);

    // Reset asserted while a store is in XFER.
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'hBEEF; bgrt_ = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus_rw_ === 1'b0) seen = 1'b1;
    end
    check("rst_xfer_reached", seen, 1);
    reset_ = 1'b0; cpu_memwrite = 1'b0; bgrt_ = 1'b1;
    #1;
    check("midrst_breq", breq_, 1);
    check("midrst_stall", cpu_stall, 0);
    check("midrst_rw", bus_rw_, 1);
    check("midrst_addr", bus_addr, 0);
    check("midrst_rdata", cpu_rdata, 0);
    check("midrst_err", err, 0);
    wc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_rw_ === 1'b0) wc++;
    end
    reset_ = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_rw_ === 1'b0) wc++;
    end
    check("midrst_no_write", wc, 0);
    m_rdata = '0; m_err = 1'b0;

    // Normal operation resumes after reset.
    run_txn(1'b1, 1'b0, 16'h0066, 16'h0000, 16'hC0DE, 2);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
